sram_like_responder: RTL

SRAM_LIKE_RESPONDER -- requirements
Module: sram_like_responder

---
 rtl/sram_like_pkg.sv | 33 +++
 rtl/resp_fifo.sv | 54 +++++
 rtl/sram_like_responder.sv | 99 +++++++++
 3 files changed

// File: rtl/sram_like_pkg.sv
// Shared types, widths and the byte-strobe helper for the SRAM-like responder.
package sram_like_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    SIZE_BYTE     = 2'd0,
    SIZE_HALF     = 2'd1,
    SIZE_WORD     = 2'd2,
    SIZE_WORD_ALT = 2'd3
  } size_e;

  // One response buffer entry: read data (zero for writes) plus the write flag.
  typedef struct packed {
    logic              wr;
    logic [DATA_W-1:0] data;
  } resp_t;

  // Byte-lane strobes; low address bits below the access size are ignored.
  function automatic logic [STRB_W-1:0] byte_strobe(input logic [1:0] size,
                                                    input logic [1:0] lo);
    logic [STRB_W-1:0] strb;
    case (size)
      SIZE_BYTE: strb = 4'b0001 << lo;
      SIZE_HALF: strb = 4'b0011 << {lo[1], 1'b0};
      default:   strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/resp_fifo.sv
// In-order response buffer with fall-through when empty, so a response whose
// RAM data arrives in the same cycle as its data_ok is passed straight out.
module resp_fifo
  import sram_like_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic  clk,
  input  logic  resetn,
  input  logic  push,
  input  logic  pop,
  input  resp_t push_data,
  output resp_t head
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  resp_t          mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           empty;
  logic           store;
  logic           take;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty = (count == '0);
  assign store = push && !(pop && empty);
  assign take  = pop && !empty;
  assign head  = empty ? push_data : mem[rd_ptr];

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (store) wr_ptr <= bump(wr_ptr);
      if (take)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(store) - CW'(take);
    end
  end

  // Entry storage; validity is carried by the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sram_like_responder.sv
// SRAM-like bus responder: accepts requests onto a synchronous RAM and returns
// one data_ok per request, in order, a fixed RESP_DELAY cycles after acceptance.
module sram_like_responder
  import sram_like_pkg::*;
#(
  parameter int unsigned RESP_DELAY      = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_en,
  output logic [STRB_W-1:0] ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  logic                  run;
  logic [CW-1:0]         count;
  logic                  accept;
  logic [RESP_DELAY-1:0] delay_vld;
  logic                  cap_vld;
  logic                  cap_wr;
  resp_t                 cap_resp;
  resp_t                 head;

  assign addr_ok   = run && (count < CW'(MAX_OUTSTANDING));
  assign accept    = req && addr_ok;
  assign ram_en    = accept;
  assign ram_wen   = (accept && wr) ? byte_strobe(size, addr[1:0]) : '0;
  assign ram_addr  = {addr[ADDR_W-1:2], 2'b00};
  assign ram_wdata = wdata;
  assign data_ok   = delay_vld[RESP_DELAY-1];
  assign rdata     = (data_ok && !head.wr) ? head.data : '0;

  // Ready flag (first edge after reset) and outstanding-request count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run   <= 1'b0;
      count <= '0;
    end else begin
      run   <= 1'b1;
      count <= count + CW'(accept) - CW'(data_ok);
    end
  end

  // Per-request valid shift register; its last stage is data_ok.
  if (RESP_DELAY == 1) begin : g_delay1
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) delay_vld <= '0;
      else         delay_vld <= accept;
    end
  end else begin : g_delayn
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) delay_vld <= '0;
      else         delay_vld <= {delay_vld[RESP_DELAY-2:0], accept};
    end
  end

  // Marks the cycle in which the RAM returns data for last cycle's request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cap_vld <= 1'b0;
      cap_wr  <= 1'b0;
    end else begin
      cap_vld <= accept;
      cap_wr  <= accept && wr;
    end
  end

  // Buffer entry built from the RAM word; writes carry zero data.
  always_comb begin
    cap_resp      = '0;
    cap_resp.wr   = cap_wr;
    cap_resp.data = cap_wr ? '0 : ram_rdata;
  end

  resp_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_resp_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (cap_vld),
    .pop       (data_ok),
    .push_data (cap_resp),
    .head      (head)
  );

endmodule
